// File: rtl/vector_load_gather_if.sv
// Data-memory read port used by the vector load gather sequencer.
// The master issues one request at a time and holds it until acknowledged.
interface vector_load_gather_if #(
  parameter int DW  = 32,
  parameter int MAW = 32
);
  logic           mem_req;
  logic [MAW-1:0] mem_addr;
  logic           mem_ack;
  logic [DW-1:0]  mem_rdata;

  modport master (output mem_req, mem_addr, input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/vector_load_gather.sv
// Vector load sequencer: gathers up to 8 strided 32-bit elements from data
// memory, one request at a time, then issues a single-cycle vector register write.
module vector_load_gather #(
  parameter int DW    = 32,
  parameter int MAW   = 32,
  parameter int LANES = 8,
  parameter int RAW   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [MAW-1:0]         base_addr,
  input  logic [MAW-1:0]         stride,
  input  logic [RAW-1:0]         vd,
  input  logic [31:0]            vlen,
  vector_load_gather_if.master   mem,
  output logic                   vreg_write,
  output logic [RAW-1:0]         vreg_addr,
  output logic [DW-1:0]          vdata_0,
  output logic [DW-1:0]          vdata_1,
  output logic [DW-1:0]          vdata_2,
  output logic [DW-1:0]          vdata_3,
  output logic [DW-1:0]          vdata_4,
  output logic [DW-1:0]          vdata_5,
  output logic [DW-1:0]          vdata_6,
  output logic [DW-1:0]          vdata_7,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, REQ, COMMIT, FIN} state_t;

  state_t         state, state_next;
  logic [MAW-1:0] cur_addr;
  logic [MAW-1:0] stride_q;
  logic [RAW-1:0] vd_q;
  logic [3:0]     n_q;
  logic [3:0]     idx;
  logic [3:0]     n_in;
  logic [DW-1:0]  lane   [LANES];
  logic [DW-1:0]  vdata_q[LANES];
  logic           ack_fire;
  logic           last_ack;

  // Element count clamped to the lane count; only the low 32 bits of vlen exist.
  assign n_in     = (vlen > 32'd8) ? 4'd8 : vlen[3:0];
  assign ack_fire = (state == REQ) && mem.mem_ack;
  assign last_ack = ack_fire && ((idx + 4'd1) == n_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (n_in != 4'd0) ? REQ : FIN;
      REQ:     if (last_ack) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state so an asynchronous reset drops them at once.
  always_comb begin
    mem.mem_req = (state == REQ);
    vreg_write  = (state == COMMIT);
    done        = (state == COMMIT) || (state == FIN);
    busy        = (state != IDLE);
  end

  assign mem.mem_addr = cur_addr;

  // Datapath: operand latches, lane buffers and the registered write payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr  <= '0;
      stride_q  <= '0;
      vd_q      <= '0;
      n_q       <= '0;
      idx       <= '0;
      vreg_addr <= '0;
      // NOTE: lane and payload arrays are reset too, because a reset must leave
      // every visible lane at zero rather than stale data from an aborted load.
      for (int k = 0; k < LANES; k++) begin
        lane[k]    <= '0;
        vdata_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every read below sees the
      // pre-edge value (idx, lane[]) regardless of statement order.
      if (state == IDLE && start) begin
        cur_addr <= base_addr;
        stride_q <= stride;
        vd_q     <= vd;
        n_q      <= n_in;
        idx      <= '0;
        for (int k = 0; k < LANES; k++) lane[k] <= '0;
      end
      if (ack_fire) begin
        lane[idx[2:0]] <= mem.mem_rdata;
        idx            <= idx + 4'd1;
        cur_addr       <= cur_addr + stride_q;
        // Payload is captured on the final ack so it is valid during COMMIT
        // and then holds until the next completed load.
        if (last_ack) begin
          vreg_addr <= vd_q;
          for (int k = 0; k < LANES; k++)
            vdata_q[k] <= (idx == 4'(k)) ? mem.mem_rdata : lane[k];
        end
      end
    end
  end

  assign vdata_0 = vdata_q[0];
  assign vdata_1 = vdata_q[1];
  assign vdata_2 = vdata_q[2];
  assign vdata_3 = vdata_q[3];
  assign vdata_4 = vdata_q[4];
  assign vdata_5 = vdata_q[5];
  assign vdata_6 = vdata_q[6];
  assign vdata_7 = vdata_q[7];

endmodule
